// File: rtl/multicycle_datapath.sv
// Multicycle datapath: five-state FSM (IDLE/DECODE/EXEC/MEM/WB) with a register file,
// a word-addressed data memory and a small ALU; one instruction in flight at a time.
module multicycle_datapath #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int MEM_ADDR_W = 7,
   parameter int SLT_SIGNED = 1
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              instrValid,
   output logic              instrReady,
   input  logic [31:0]       instruction,
   input  logic              RegDst,
   input  logic              MemRead,
   input  logic              MemtoReg,
   input  logic              MemWrite,
   input  logic              ALUSrc,
   input  logic              RegWrite,
   input  logic [3:0]        ALUCtrl,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              illegalOp
);

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

   state_t                  r_state, w_next;
   logic [REG_ADDR_W-1:0]   r_rs, r_rt, r_rd;
   logic [15:0]             r_imm;
   logic                    r_regDst, r_memRead, r_memtoReg, r_memWrite, r_aluSrc, r_regWrite;
   logic [3:0]              r_aluCtrl;
   logic [DATA_W-1:0]       r_a, r_b, r_immExt, r_aluOut, r_mdr;
   logic                    r_illegal;
   logic                    r_done, r_illegalOp;
   logic [DATA_W-1:0]       r_result;
   logic [DATA_W-1:0]       r_regs [2**REG_ADDR_W];
   logic [DATA_W-1:0]       r_mem  [2**MEM_ADDR_W];

   logic [DATA_W-1:0]       w_immExt, w_aluB, w_aluRes, w_wbData;
   logic                    w_lt, w_illegal;
   logic [MEM_ADDR_W-1:0]   w_addr;
   logic [REG_ADDR_W-1:0]   w_wrAddr;
   logic                    w_unused;

   // opcode/funct bits carry no meaning here; controls arrive on dedicated ports
   assign w_unused   = ^instruction;

   assign instrReady = (r_state == S_IDLE);
   assign done       = r_done;
   assign result     = r_result;
   assign illegalOp  = r_illegalOp;

   assign w_immExt = DATA_W'($signed(r_imm));
   assign w_aluB   = r_aluSrc ? r_immExt : r_b;
   assign w_lt     = (SLT_SIGNED != 0) ? ($signed(r_a) < $signed(w_aluB)) : (r_a < w_aluB);
   assign w_addr   = r_aluOut[MEM_ADDR_W-1:0];
   assign w_wrAddr = r_regDst ? r_rt : r_rd;
   assign w_wbData = r_memtoReg ? r_mdr : r_aluOut;

   always_comb begin
      w_aluRes  = '0;
      w_illegal = 1'b0;
      case (r_aluCtrl)
         4'b0000: w_aluRes = r_a & w_aluB;
         4'b0001: w_aluRes = r_a | w_aluB;
         4'b0010: w_aluRes = r_a + w_aluB;
         4'b0110: w_aluRes = r_a - w_aluB;
         4'b1100: w_aluRes = ~(r_a | w_aluB);
         4'b0111: w_aluRes = {{(DATA_W-1){1'b0}}, w_lt};
         default: w_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (instrValid) w_next = S_DECODE;
         S_DECODE: w_next = S_EXEC;
         S_EXEC: begin
            if (r_memRead || r_memWrite) w_next = S_MEM;
            else if (r_regWrite)         w_next = S_WB;
            else                         w_next = S_IDLE;
         end
         S_MEM:    w_next = r_regWrite ? S_WB : S_IDLE;
         S_WB:     w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Memory is never cleared; the reset term only blocks a write in a reset cycle.
   always_ff @(posedge clk) begin
      if (resetN && r_state == S_MEM && r_memWrite) r_mem[w_addr] <= r_b;
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_rs <= '0; r_rt <= '0; r_rd <= '0; r_imm <= '0;
         r_regDst <= 1'b0; r_memRead <= 1'b0; r_memtoReg <= 1'b0;
         r_memWrite <= 1'b0; r_aluSrc <= 1'b0; r_regWrite <= 1'b0;
         r_aluCtrl <= '0;
         r_a <= '0; r_b <= '0; r_immExt <= '0; r_aluOut <= '0; r_mdr <= '0;
         r_illegal <= 1'b0;
         r_done <= 1'b0; r_result <= '0; r_illegalOp <= 1'b0;
         for (int i = 0; i < 2**REG_ADDR_W; i++) r_regs[i] <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (instrValid) begin
                  r_rs       <= instruction[21 +: REG_ADDR_W];
                  r_rt       <= instruction[16 +: REG_ADDR_W];
                  r_rd       <= instruction[11 +: REG_ADDR_W];
                  r_imm      <= instruction[15:0];
                  r_regDst   <= RegDst;
                  r_memRead  <= MemRead;
                  r_memtoReg <= MemtoReg;
                  r_memWrite <= MemWrite;
                  r_aluSrc   <= ALUSrc;
                  r_regWrite <= RegWrite;
                  r_aluCtrl  <= ALUCtrl;
               end
            end
            S_DECODE: begin
               r_a      <= r_regs[r_rs];
               r_b      <= r_regs[r_rt];
               r_immExt <= w_immExt;
            end
            S_EXEC: begin
               r_aluOut  <= w_aluRes;
               r_illegal <= w_illegal;
               if (w_next == S_IDLE) begin
                  r_done      <= 1'b1;
                  r_result    <= w_aluRes;
                  r_illegalOp <= w_illegal;
               end
            end
            S_MEM: begin
               if (r_memRead) r_mdr <= r_mem[w_addr];
               if (!r_regWrite) begin
                  r_done      <= 1'b1;
                  r_result    <= r_aluOut;
                  r_illegalOp <= r_illegal;
               end
            end
            S_WB: begin
               // r0 stays zero: its write is dropped but the instruction still completes
               if (w_wrAddr != '0) r_regs[w_wrAddr] <= w_wbData;
               r_done      <= 1'b1;
               r_result    <= w_wbData;
               r_illegalOp <= r_illegal;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench: expected result/illegal/latency queued at drive time, checked on done.
module tb_multicycle_datapath;

   localparam int DW = 32;

   localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                          A_SUB = 4'b0110, A_NOR = 4'b1100, A_SLT = 4'b0111;
   // {RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}
   localparam logic [5:0] C_ADDI = 6'b100011, C_RD = 6'b000000, C_RW = 6'b000001,
                          C_ST = 6'b000110, C_LD = 6'b111011, C_RMW = 6'b011111;

   logic clk = 1'b0, resetN = 1'b0, instrValid = 1'b0;
   logic [31:0] instruction = '0;
   logic RegDst = 0, MemRead = 0, MemtoReg = 0, MemWrite = 0, ALUSrc = 0, RegWrite = 0;
   logic [3:0] ALUCtrl = '0;
   logic instrReady, done, illegalOp, rdy_u, done_u, ill_u;
   logic [DW-1:0] result, res_u;

   int total = 0, bad = 0, cyc = 0;

   typedef struct {logic [DW-1:0] res; logic ill; int acc; int lat;} exp_t;
   exp_t q[$];
   exp_t e;

   multicycle_datapath #(.DATA_W(DW), .REG_ADDR_W(5), .MEM_ADDR_W(7), .SLT_SIGNED(1)) dut (
      .clk(clk), .resetN(resetN), .instrValid(instrValid), .instrReady(instrReady),
      .instruction(instruction), .RegDst(RegDst), .MemRead(MemRead), .MemtoReg(MemtoReg),
      .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUCtrl(ALUCtrl),
      .done(done), .result(result), .illegalOp(illegalOp));

   multicycle_datapath #(.DATA_W(DW), .REG_ADDR_W(5), .MEM_ADDR_W(7), .SLT_SIGNED(0)) dut_u (
      .clk(clk), .resetN(resetN), .instrValid(instrValid), .instrReady(rdy_u),
      .instruction(instruction), .RegDst(RegDst), .MemRead(MemRead), .MemtoReg(MemtoReg),
      .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUCtrl(ALUCtrl),
      .done(done_u), .result(res_u), .illegalOp(ill_u));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) chk("unexp_done", 64'd1, 64'd0);
         else begin
            e = q.pop_front();
            chk("result", 64'(result), 64'(e.res));
            chk("illegal", 64'(illegalOp), 64'(e.ill));
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
         end
      end
   end

   function automatic logic [31:0] itype(input int rs, input int rt, input logic [15:0] imm);
      return {6'd0, 5'(rs), 5'(rt), imm};
   endfunction
   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [5:0] ctl, input logic [3:0] alu);
      int n = 0;
      while (!instrReady && n < 20) begin @(negedge clk); n++; end
      if (!instrReady) chk("ready_timeout", 64'd0, 64'd1);
      instruction = ins;
      {RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite} = ctl;
      ALUCtrl = alu;
      instrValid = 1'b1;
   endtask

   // Issue one instruction, queue its expectation, wait (bounded) for completion.
   task automatic exec(input logic [31:0] ins, input logic [5:0] ctl, input logic [3:0] alu,
                       input logic [DW-1:0] res, input logic ill, input int lat, input bit hold);
      bit got = 0;
      drive(ins, ctl, alu);
      q.push_back('{res: res, ill: ill, acc: cyc + 1, lat: lat});
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0 && !hold) begin
            instrValid  = 1'b0;
            instruction = $urandom;
            ALUCtrl     = 4'($urandom);
         end
         if (done) begin got = 1; break; end
      end
      instrValid = 1'b0;
      if (!got) chk("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic rd_reg(input int r, input logic [DW-1:0] v);
      exec(rtype(r, 0, 0), C_RD, A_OR, v, 1'b0, 2, 0);
   endtask

   // Reset lands on the edge that would end the stage reached after nneg cycles.
   task automatic rst_in(input logic [31:0] ins, input logic [5:0] ctl, input int nneg);
      drive(ins, ctl, A_ADD);
      for (int i = 0; i < nneg; i++) begin
         @(negedge clk);
         instrValid = 1'b0;
      end
      resetN = 1'b0;
      @(negedge clk);
      chk("rst_done", 64'(done), 64'd0);
      resetN = 1'b1;
      chk("rst_ready", 64'(instrReady), 64'd1);
      @(negedge clk);
      chk("rst_done2", 64'(done), 64'd0);
   endtask

   initial begin
      // reset held with a valid instruction present: nothing may be accepted
      instruction = itype(0, 3, 16'h0005);
      {RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite} = C_ADDI;
      ALUCtrl = A_ADD;
      instrValid = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(instrReady), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_illegal", 64'(illegalOp), 64'd0);
      instrValid = 1'b0;
      resetN = 1'b1;
      @(negedge clk);

      exec(itype(0, 3, 16'h0005), C_ADDI, A_ADD, 5, 0, 3, 0);
      rd_reg(3, 5);
      exec(itype(0, 1, 16'hFFFF), C_ADDI, A_ADD, 32'hFFFF_FFFF, 0, 3, 0);
      exec(itype(0, 1, 16'd3), C_ST, A_ADD, 3, 0, 3, 0);
      exec(itype(0, 2, 16'd3), C_LD, A_ADD, 32'hFFFF_FFFF, 0, 4, 0);
      rd_reg(2, 32'hFFFF_FFFF);
      exec(itype(0, 2, 16'd131), C_LD, A_ADD, 32'hFFFF_FFFF, 0, 4, 0);
      exec(itype(0, 3, 16'd131), C_ST, A_ADD, 131, 0, 3, 0);
      exec(itype(0, 2, 16'd3), C_LD, A_ADD, 5, 0, 4, 0);

      exec(itype(0, 4, 16'd1), C_ADDI, A_ADD, 1, 0, 3, 0);
      exec(itype(0, 5, 16'hFFFF), C_ADDI, A_ADD, 32'hFFFF_FFFF, 0, 3, 0);
      exec(rtype(4, 5, 9), C_RW, A_SLT, 0, 0, 3, 0);
      chk("slt_u", 64'(res_u), 64'd1);
      @(negedge clk);
      chk("hold_result", 64'(result), 64'd0);
      exec(rtype(5, 4, 9), C_RD, A_SLT, 1, 0, 2, 0);
      chk("slt_u_rev", 64'(res_u), 64'd0);
      exec(rtype(4, 5, 0), C_RD, A_AND, 1, 0, 2, 0);
      exec(rtype(4, 5, 0), C_RD, A_OR, 32'hFFFF_FFFF, 0, 2, 0);
      exec(rtype(4, 5, 0), C_RD, A_SUB, 2, 0, 2, 0);
      exec(rtype(5, 4, 0), C_RD, A_SUB, 32'hFFFF_FFFE, 0, 2, 0);
      exec(rtype(4, 5, 0), C_RD, A_NOR, 0, 0, 2, 0);
      exec(rtype(4, 5, 0), C_RD, A_ADD, 0, 0, 2, 0);
      exec(rtype(3, 4, 8), C_RW, A_ADD, 6, 0, 3, 0);
      rd_reg(8, 6);

      // read-modify-write: rd=11, address 3; mdr takes the old word
      exec(itype(0, 5, 16'h5803), C_RMW, A_ADD, 5, 0, 4, 0);
      exec(itype(0, 2, 16'd3), C_LD, A_ADD, 32'hFFFF_FFFF, 0, 4, 0);
      rd_reg(11, 5);

      exec(itype(0, 7, 16'd9), C_ADDI, A_ADD, 9, 0, 3, 0);
      exec(rtype(4, 5, 7), C_RW, 4'b1010, 0, 1, 3, 0);
      rd_reg(7, 0);
      exec(itype(0, 0, 16'd7), C_ADDI, A_ADD, 7, 0, 3, 0);
      rd_reg(0, 0);

      exec(itype(4, 10, 16'd2), C_ADDI, A_ADD, 3, 0, 3, 1);
      rd_reg(10, 3);

      exec(itype(0, 1, 16'h0077), C_ADDI, A_ADD, 32'h77, 0, 3, 0);
      exec(itype(0, 1, 16'd20), C_ST, A_ADD, 20, 0, 3, 0);
      exec(itype(0, 1, 16'h0055), C_ADDI, A_ADD, 32'h55, 0, 3, 0);
      rst_in(itype(0, 1, 16'd20), C_ST, 3);
      exec(itype(0, 2, 16'd20), C_LD, A_ADD, 32'h77, 0, 4, 0);

      rst_in(itype(0, 6, 16'd9), C_ADDI, 3);
      rd_reg(6, 0);

      repeat (3) @(negedge clk);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
